stream_demux: RTL and testbench

//  Parametrised, registered 1-to-N_OUT stream demultiplexer with valid/ready handshake on every port.

---
 rtl/demux_pkg.sv | 21 ++
 rtl/demux_slot.sv | 36 +++
 rtl/stream_demux.sv | 115 +++++++++++
 tb/tb_stream_demux.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared types and helpers for the stream demultiplexer.
// Provides the FSM state type and a constant log2 used to size the select field.
package demux_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } demux_state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output holding slot for a single demux channel.
// Refill wins over drain, so a beat can leave and a new one arrive in the same cycle.
module demux_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             last,
    input  logic             ready,
    output logic             valid,
    output logic             free,
    output logic [WIDTH-1:0] q_data,
    output logic             q_last
);

    assign free = !valid || ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid  <= 1'b0;
            q_data <= '0;
            q_last <= 1'b0;
        end else if (load) begin
            valid  <= 1'b1;
            q_data <= data;
            q_last <= last;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-N_OUT stream demultiplexer with per-packet channel lock.
// Beats aimed at a channel index >= N_OUT are swallowed and counted.
module stream_demux
    import demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_OUT = 4,
    parameter int SEL_W = clog2(N_OUT),
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [SEL_W-1:0]       in_sel,
    input  logic                   in_last,
    output logic [N_OUT-1:0]       out_valid,
    input  logic [N_OUT-1:0]       out_ready,
    output logic [N_OUT*WIDTH-1:0] out_data,
    output logic [N_OUT-1:0]       out_last,
    output logic                   busy,
    output logic [CNT_W-1:0]       drop_cnt
);

    localparam logic [SEL_W:0] N_OUT_L = (SEL_W + 1)'(N_OUT);

    demux_state_e     state_q, state_d;
    logic [SEL_W-1:0] lock_sel_q, lock_sel_d;
    logic [SEL_W-1:0] tgt;
    logic             en_q;
    logic             tgt_ok;
    logic             tgt_free;
    logic             accept;
    logic [N_OUT-1:0] load;
    logic [N_OUT-1:0] slot_free;

    assign busy = (state_q == ST_LOCKED);
    assign tgt  = busy ? lock_sel_q : in_sel;

    assign tgt_ok   = ({1'b0, tgt} < N_OUT_L);
    // en_q keeps in_ready low during reset and releases it one edge later
    assign in_ready = en_q && (!tgt_ok || tgt_free);
    assign accept   = in_valid && in_ready;

    always_comb begin
        tgt_free = 1'b0;
        load     = '0;
        for (int unsigned k = 0; k < N_OUT; k++) begin
            if (tgt == SEL_W'(k)) begin
                tgt_free = slot_free[k];
                load[k]  = accept && tgt_ok;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        lock_sel_d = lock_sel_q;
        if (accept) begin
            case (state_q)
                ST_IDLE: begin
                    if (!in_last) begin
                        state_d    = ST_LOCKED;
                        lock_sel_d = in_sel;
                    end
                end
                ST_LOCKED: begin
                    if (in_last) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            lock_sel_q <= '0;
            en_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_sel_q <= lock_sel_d;
            en_q       <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (accept && !tgt_ok && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

    for (genvar k = 0; k < N_OUT; k++) begin : g_slot
        demux_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (load[k]),
            .data  (in_data),
            .last  (in_last),
            .ready (out_ready[k]),
            .valid (out_valid[k]),
            .free  (slot_free[k]),
            .q_data(out_data[k*WIDTH +: WIDTH]),
            .q_last(out_last[k])
        );
    end

endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench for stream_demux: directed tables, corner-case sequences
// and random traffic compared against a per-channel slot model.
module tb_stream_demux;

    localparam int WIDTH = 8;
    localparam int N_OUT = 3;
    localparam int SEL_W = 2;
    localparam int CNT_W = 4;

    logic                   clk;
    logic                   rst_n;
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_data;
    logic [SEL_W-1:0]       in_sel;
    logic                   in_last;
    logic [N_OUT-1:0]       out_valid;
    logic [N_OUT-1:0]       out_ready;
    logic [N_OUT*WIDTH-1:0] out_data;
    logic [N_OUT-1:0]       out_last;
    logic                   busy;
    logic [CNT_W-1:0]       drop_cnt;

    stream_demux #(
        .WIDTH(WIDTH),
        .N_OUT(N_OUT),
        .SEL_W(SEL_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last),
        .busy     (busy),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: each channel is a queue of depth at most one; packet state is
    // just "which channel is the open packet going to" (-1 = none).
    bit         m_valid [N_OUT];
    logic [7:0] m_data  [N_OUT];
    bit         m_last  [N_OUT];
    int         m_open;
    int         m_drops;
    bit         m_en;

    typedef struct {
        bit         v;
        logic [1:0] sel;
        logic [7:0] data;
        bit         last;
        logic [2:0] ordy;
        logic [2:0] exp_valid;
        logic [7:0] exp_data;
        int         exp_ch;
        logic [3:0] exp_drop;
    } vec_t;

    vec_t tbl[$];

    task automatic expect_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic int m_tgt();
        return (m_open >= 0) ? m_open : int'(in_sel);
    endfunction

    function automatic bit m_in_ready();
        int t;
        t = m_tgt();
        if (!m_en) return 1'b0;
        if (t >= N_OUT) return 1'b1;
        return !m_valid[t] || out_ready[t];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N_OUT; k++) begin
            m_valid[k] = 1'b0;
            m_data[k]  = '0;
            m_last[k]  = 1'b0;
        end
        m_open  = -1;
        m_drops = 0;
        m_en    = 1'b0;
    endtask

    task automatic model_edge();
        int t;
        bit acc;
        if (!rst_n) begin
            model_reset();
            return;
        end
        t   = m_tgt();
        acc = in_valid && m_in_ready();
        for (int k = 0; k < N_OUT; k++) begin
            if (m_valid[k] && out_ready[k]) m_valid[k] = 1'b0;
        end
        if (acc) begin
            if (t < N_OUT) begin
                m_valid[t] = 1'b1;
                m_data[t]  = in_data;
                m_last[t]  = in_last;
            end else if (m_drops < 15) begin
                m_drops++;
            end
            if (m_open < 0 && !in_last) m_open = int'(in_sel);
            else if (m_open >= 0 && in_last) m_open = -1;
        end
        m_en = 1'b1;
    endtask

    task automatic check_model();
        logic [2:0] ev;
        for (int k = 0; k < N_OUT; k++) ev[k] = m_valid[k];
        expect_eq("m_out_valid", 32'(out_valid), 32'(ev));
        for (int k = 0; k < N_OUT; k++) begin
            if (m_valid[k]) begin
                expect_eq($sformatf("m_data_ch%0d", k), 32'(out_data[k*WIDTH +: WIDTH]), 32'(m_data[k]));
                expect_eq($sformatf("m_last_ch%0d", k), 32'(out_last[k]), 32'(m_last[k]));
            end
        end
        expect_eq("m_in_ready", 32'(in_ready), 32'(m_in_ready()));
        expect_eq("m_busy", 32'(busy), 32'(m_open >= 0));
        expect_eq("m_drop_cnt", 32'(drop_cnt), 32'(m_drops));
    endtask

    task automatic cycle();
        @(negedge clk);
        check_model();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input bit v, input logic [1:0] s, input logic [7:0] d,
                         input bit l, input logic [2:0] r);
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        in_last   = l;
        out_ready = r;
    endtask

    function automatic logic [31:0] ch_data(input int k);
        return 32'(out_data[k*WIDTH +: WIDTH]);
    endfunction

    initial begin
        rst_n = 1'b0;
        model_reset();
        drive(0, 0, 8'h00, 0, 3'b111);

        // Reset state
        repeat (2) cycle();
        expect_eq("rst_data", 32'(out_data), 32'h0);
        expect_eq("rst_last", 32'(out_last), 32'h0);
        expect_eq("rst_in_ready", 32'(in_ready), 32'h0);
        rst_n = 1'b1;
        cycle();

        // Single beats and drop saturation from a table
        tbl.push_back('{1, 2'd0, 8'hA1, 1, 3'b111, 3'b001, 8'hA1, 0, 4'd0});
        tbl.push_back('{1, 2'd1, 8'hB2, 1, 3'b111, 3'b010, 8'hB2, 1, 4'd0});
        tbl.push_back('{1, 2'd2, 8'hC3, 1, 3'b111, 3'b100, 8'hC3, 2, 4'd0});
        tbl.push_back('{0, 2'd0, 8'h00, 0, 3'b111, 3'b000, 8'h00, -1, 4'd0});
        for (int i = 0; i < 20; i++) begin
            tbl.push_back('{1, 2'd3, 8'(i), 1, 3'b111, 3'b000, 8'h00, -1,
                            4'((i + 1 > 15) ? 15 : i + 1)});
        end
        tbl.push_back('{0, 2'd0, 8'h00, 0, 3'b111, 3'b000, 8'h00, -1, 4'd15});

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].sel, tbl[i].data, tbl[i].last, tbl[i].ordy);
            cycle();
            expect_eq($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].exp_valid));
            if (tbl[i].exp_ch >= 0)
                expect_eq($sformatf("tbl%0d_data", i), ch_data(tbl[i].exp_ch), 32'(tbl[i].exp_data));
            expect_eq($sformatf("tbl%0d_drop", i), 32'(drop_cnt), 32'(tbl[i].exp_drop));
        end

        // Packet lock: in_sel changes after the first beat are ignored
        drive(1, 2'd1, 8'h10, 0, 3'b111);
        cycle();
        expect_eq("lock_busy0", 32'(busy), 32'h1);
        expect_eq("lock_v0", 32'(out_valid), 32'b010);
        expect_eq("lock_d0", ch_data(1), 32'h10);
        drive(1, 2'd0, 8'h11, 0, 3'b111);
        cycle();
        expect_eq("lock_busy1", 32'(busy), 32'h1);
        expect_eq("lock_v1", 32'(out_valid), 32'b010);
        expect_eq("lock_d1", ch_data(1), 32'h11);
        drive(1, 2'd2, 8'h12, 1, 3'b111);
        cycle();
        expect_eq("lock_busy2", 32'(busy), 32'h0);
        expect_eq("lock_v2", 32'(out_valid), 32'b010);
        expect_eq("lock_d2", ch_data(1), 32'h12);
        expect_eq("lock_last2", 32'(out_last[1]), 32'h1);
        drive(0, 2'd0, 8'h00, 0, 3'b111);
        cycle();

        // Backpressure on channel 2, then release with no bubble
        drive(1, 2'd2, 8'h31, 1, 3'b011);
        cycle();
        expect_eq("bp_v0", 32'(out_valid), 32'b100);
        expect_eq("bp_d0", ch_data(2), 32'h31);
        drive(1, 2'd2, 8'h32, 1, 3'b011);
        #2;
        expect_eq("bp_rdy_low", 32'(in_ready), 32'h0);
        repeat (2) begin
            cycle();
            expect_eq("bp_hold_v", 32'(out_valid), 32'b100);
            expect_eq("bp_hold_d", ch_data(2), 32'h31);
        end
        out_ready = 3'b111;
        #2;
        expect_eq("bp_rdy_high", 32'(in_ready), 32'h1);
        cycle();
        expect_eq("bp_v1", 32'(out_valid), 32'b100);
        expect_eq("bp_d1", ch_data(2), 32'h32);
        drive(0, 2'd0, 8'h00, 0, 3'b111);
        cycle();
        expect_eq("bp_empty", 32'(out_valid), 32'b000);

        // Isolation: ch0 stalled with a beat, ch1 streams at full rate
        drive(1, 2'd0, 8'hD0, 1, 3'b110);
        cycle();
        for (int i = 0; i < 4; i++) begin
            drive(1, 2'd1, 8'(8'h50 + i), (i == 3), 3'b110);
            #1;
            expect_eq("iso_rdy", 32'(in_ready), 32'h1);
            cycle();
            expect_eq("iso_v", 32'(out_valid), 32'b011);
            expect_eq("iso_d1", ch_data(1), 32'(8'h50 + i));
            expect_eq("iso_d0", ch_data(0), 32'hD0);
        end
        drive(0, 2'd0, 8'h00, 0, 3'b111);
        cycle();
        expect_eq("iso_drained", 32'(out_valid), 32'b000);

        // Asynchronous reset in the middle of a 4-beat packet
        drive(1, 2'd0, 8'h60, 0, 3'b111);
        cycle();
        drive(1, 2'd0, 8'h61, 0, 3'b111);
        cycle();
        drive(1, 2'd0, 8'h62, 0, 3'b111);
        #2;
        rst_n = 1'b0;
        #1;
        expect_eq("arst_valid", 32'(out_valid), 32'h0);
        expect_eq("arst_data", 32'(out_data), 32'h0);
        expect_eq("arst_last", 32'(out_last), 32'h0);
        expect_eq("arst_busy", 32'(busy), 32'h0);
        expect_eq("arst_drop", 32'(drop_cnt), 32'h0);
        expect_eq("arst_rdy", 32'(in_ready), 32'h0);
        model_reset();
        repeat (2) cycle();
        rst_n = 1'b1;
        drive(1, 2'd2, 8'h70, 0, 3'b111);
        cycle();
        cycle();
        expect_eq("post_v0", 32'(out_valid), 32'b100);
        expect_eq("post_d0", ch_data(2), 32'h70);
        expect_eq("post_busy0", 32'(busy), 32'h1);
        drive(1, 2'd0, 8'h71, 1, 3'b111);
        cycle();
        expect_eq("post_v1", 32'(out_valid), 32'b100);
        expect_eq("post_d1", ch_data(2), 32'h71);
        expect_eq("post_busy1", 32'(busy), 32'h0);
        drive(0, 2'd0, 8'h00, 0, 3'b111);
        cycle();

        // Random traffic against the model
        for (int i = 0; i < 2000; i++) begin
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom),
                  ($urandom_range(0, 2) == 0), 3'($urandom));
            cycle();
        end
        drive(0, 2'd0, 8'h00, 0, 3'b111);
        repeat (2) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
